// File: rtl/dcache_event_monitor_pkg.sv
// Shared definitions for the data-cache event monitor.
//   - Event code encodings reported on ev_code_o.
//   - Maximum supported channel count (ev_ch_o is 3 bits wide).
//   - Decoder from an event code to the set of counters it bumps.
package dcache_event_monitor_pkg;

  localparam int MAX_CH    = 8;
  localparam int EV_CODE_W = 3;
  localparam int EV_CH_W   = 3;

  localparam logic [EV_CODE_W-1:0] EV_CODE_NONE       = 3'd0;
  localparam logic [EV_CODE_W-1:0] EV_CODE_RD_HIT     = 3'd1;
  localparam logic [EV_CODE_W-1:0] EV_CODE_WR_HIT     = 3'd2;
  localparam logic [EV_CODE_W-1:0] EV_CODE_RD_MISS    = 3'd3;
  localparam logic [EV_CODE_W-1:0] EV_CODE_WR_MISS    = 3'd4;
  localparam logic [EV_CODE_W-1:0] EV_CODE_RD_MISS_WB = 3'd5;
  localparam logic [EV_CODE_W-1:0] EV_CODE_WR_MISS_WB = 3'd6;

  typedef enum logic [EV_CODE_W-1:0] {
    EV_NONE       = EV_CODE_NONE,
    EV_RD_HIT     = EV_CODE_RD_HIT,
    EV_WR_HIT     = EV_CODE_WR_HIT,
    EV_RD_MISS    = EV_CODE_RD_MISS,
    EV_WR_MISS    = EV_CODE_WR_MISS,
    EV_RD_MISS_WB = EV_CODE_RD_MISS_WB,
    EV_WR_MISS_WB = EV_CODE_WR_MISS_WB
  } ev_code_e;

  // One bit per counter: which counters a given event increments.
  typedef struct packed {
    logic rd_hit;
    logic wr_hit;
    logic rd_miss;
    logic wr_miss;
    logic wb;
  } ev_inc_t;

  function automatic ev_inc_t decode_inc(input ev_code_e code);
    ev_inc_t inc;
    inc         = '0;
    inc.rd_hit  = (code == EV_RD_HIT);
    inc.wr_hit  = (code == EV_WR_HIT);
    inc.rd_miss = (code == EV_RD_MISS) || (code == EV_RD_MISS_WB);
    inc.wr_miss = (code == EV_WR_MISS) || (code == EV_WR_MISS_WB);
    inc.wb      = (code == EV_RD_MISS_WB) || (code == EV_WR_MISS_WB);
    return inc;
  endfunction

endpackage

// File: rtl/dcache_event_monitor_if.sv
// Bundle of the monitor's cache-side inputs, control inputs and counter /
// event outputs.
//   master : the side that drives the cache status signals and controls
//   slave  : the monitor's view (consumes status, produces counters/events)
interface dcache_event_monitor_if
  import dcache_event_monitor_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 32
) (
  input logic clk
);
  logic [NUM_CH-1:0]        stall;
  logic [NUM_CH-1:0]        idle;
  logic [NUM_CH-1:0]        dirty;
  logic [NUM_CH-1:0]        rd;
  logic [NUM_CH-1:0]        wr;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic                     clear;
  logic                     freeze;
  logic [NUM_CH*CNT_W-1:0]  rd_hit;
  logic [NUM_CH*CNT_W-1:0]  wr_hit;
  logic [NUM_CH*CNT_W-1:0]  rd_miss;
  logic [NUM_CH*CNT_W-1:0]  wr_miss;
  logic [NUM_CH*CNT_W-1:0]  wb;
  logic                     ev_valid;
  logic [EV_CODE_W-1:0]     ev_code;
  logic [EV_CH_W-1:0]       ev_ch;
  logic [ADDR_W-1:0]        ev_addr;
  logic [CNT_W-1:0]         ev_drop;

  modport master (
    input  clk,
    output stall, idle, dirty, rd, wr, addr, clear, freeze,
    input  rd_hit, wr_hit, rd_miss, wr_miss, wb,
    input  ev_valid, ev_code, ev_ch, ev_addr, ev_drop
  );

  modport slave (
    input  clk,
    input  stall, idle, dirty, rd, wr, addr, clear, freeze,
    output rd_hit, wr_hit, rd_miss, wr_miss, wb,
    output ev_valid, ev_code, ev_ch, ev_addr, ev_drop
  );
endinterface

// File: rtl/dcache_event_classifier.sv
// Per-channel access classifier.
//   Tracks whether the channel is in the middle of a miss (flag) so that the
//   access replayed after the stall is not counted a second time as a hit.
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   stall_i, idle_i  : cache stall and cache-FSM-idle for this channel
//   rd_i, wr_i       : MemRead / MemWrite (write wins)
//   dirty_i          : victim line is dirty (miss needs a writeback)
//   code_o           : combinational event code for the current cycle
module dcache_event_classifier
  import dcache_event_monitor_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     stall_i,
  input  logic     idle_i,
  input  logic     rd_i,
  input  logic     wr_i,
  input  logic     dirty_i,
  output ev_code_e code_o
);
  logic     flag_q, flag_d;
  ev_code_e code_d;

  always_comb begin
    flag_d = flag_q;
    code_d = EV_NONE;
    if (stall_i) begin
      // A stall seen while the cache FSM is still idle is the first cycle of
      // a miss; later (busy) stall cycles belong to the same miss.
      if (idle_i) begin
        if (wr_i) begin
          code_d = dirty_i ? EV_WR_MISS_WB : EV_WR_MISS;
          flag_d = 1'b1;
        end else if (rd_i) begin
          code_d = dirty_i ? EV_RD_MISS_WB : EV_RD_MISS;
          flag_d = 1'b1;
        end
      end
    end else begin
      flag_d = 1'b0;
      // With the flag set this is the replay of an access already counted.
      if (!flag_q) begin
        if (wr_i) begin
          code_d = EV_WR_HIT;
        end else if (rd_i) begin
          code_d = EV_RD_HIT;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign code_o = code_d;
endmodule

// File: rtl/dcache_event_monitor.sv
// Data-cache event monitor: per-channel hit/miss/writeback counters plus a
// single registered event port reporting the lowest-numbered active channel.
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   stall_i, idle_i, dirty_i: per-channel cache status
//   rd_i, wr_i, addr_i      : per-channel access (channel 0 in the LSBs)
//   clear_i, freeze_i       : counter clear (wins) and counter hold
//   rd_hit_o .. wb_o        : per-channel saturating counters
//   ev_*_o                  : registered event port, ev_drop_o counts losers
module dcache_event_monitor
  import dcache_event_monitor_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        stall_i,
  input  logic [NUM_CH-1:0]        idle_i,
  input  logic [NUM_CH-1:0]        dirty_i,
  input  logic [NUM_CH-1:0]        rd_i,
  input  logic [NUM_CH-1:0]        wr_i,
  input  logic [NUM_CH*ADDR_W-1:0] addr_i,
  input  logic                     clear_i,
  input  logic                     freeze_i,
  output logic [NUM_CH*CNT_W-1:0]  rd_hit_o,
  output logic [NUM_CH*CNT_W-1:0]  wr_hit_o,
  output logic [NUM_CH*CNT_W-1:0]  rd_miss_o,
  output logic [NUM_CH*CNT_W-1:0]  wr_miss_o,
  output logic [NUM_CH*CNT_W-1:0]  wb_o,
  output logic                     ev_valid_o,
  output logic [EV_CODE_W-1:0]     ev_code_o,
  output logic [EV_CH_W-1:0]       ev_ch_o,
  output logic [ADDR_W-1:0]        ev_addr_o,
  output logic [CNT_W-1:0]         ev_drop_o
);
  ev_code_e ch_code [NUM_CH];

  // Clear beats freeze and beats a same-cycle increment; counters stick at
  // all-ones.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic inc,
                                                input logic clr,
                                                input logic frz);
    if (clr) return '0;
    if (frz || !inc || (&cur)) return cur;
    return cur + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ev_inc_t          inc;
      logic [CNT_W-1:0] rd_hit_q, rd_hit_d, wr_hit_q, wr_hit_d;
      logic [CNT_W-1:0] rd_miss_q, rd_miss_d, wr_miss_q, wr_miss_d;
      logic [CNT_W-1:0] wb_q, wb_d;

      dcache_event_classifier u_cls (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stall_i (stall_i[gi]),
        .idle_i  (idle_i[gi]),
        .rd_i    (rd_i[gi]),
        .wr_i    (wr_i[gi]),
        .dirty_i (dirty_i[gi]),
        .code_o  (ch_code[gi])
      );

      always_comb begin
        inc       = decode_inc(ch_code[gi]);
        rd_hit_d  = cnt_next(rd_hit_q,  inc.rd_hit,  clear_i, freeze_i);
        wr_hit_d  = cnt_next(wr_hit_q,  inc.wr_hit,  clear_i, freeze_i);
        rd_miss_d = cnt_next(rd_miss_q, inc.rd_miss, clear_i, freeze_i);
        wr_miss_d = cnt_next(wr_miss_q, inc.wr_miss, clear_i, freeze_i);
        wb_d      = cnt_next(wb_q,      inc.wb,      clear_i, freeze_i);
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          rd_hit_q  <= '0;
          wr_hit_q  <= '0;
          rd_miss_q <= '0;
          wr_miss_q <= '0;
          wb_q      <= '0;
        end else begin
          rd_hit_q  <= rd_hit_d;
          wr_hit_q  <= wr_hit_d;
          rd_miss_q <= rd_miss_d;
          wr_miss_q <= wr_miss_d;
          wb_q      <= wb_d;
        end
      end

      assign rd_hit_o [gi*CNT_W +: CNT_W] = rd_hit_q;
      assign wr_hit_o [gi*CNT_W +: CNT_W] = wr_hit_q;
      assign rd_miss_o[gi*CNT_W +: CNT_W] = rd_miss_q;
      assign wr_miss_o[gi*CNT_W +: CNT_W] = wr_miss_q;
      assign wb_o     [gi*CNT_W +: CNT_W] = wb_q;
    end
  endgenerate

  logic                 ev_valid_q, ev_valid_d;
  logic [EV_CODE_W-1:0] ev_code_q, ev_code_d;
  logic [EV_CH_W-1:0]   ev_ch_q, ev_ch_d;
  logic [ADDR_W-1:0]    ev_addr_q, ev_addr_d;
  logic [CNT_W-1:0]     ev_drop_q, ev_drop_d;
  logic [3:0]           n_ev;
  logic [CNT_W+3:0]     drop_sum;

  always_comb begin
    ev_valid_d = 1'b0;
    ev_code_d  = EV_CODE_NONE;
    ev_ch_d    = '0;
    ev_addr_d  = '0;
    n_ev       = '0;
    // Walk downwards so the lowest active channel is the last one written.
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (ch_code[c] != EV_NONE) begin
        ev_valid_d = 1'b1;
        ev_code_d  = ch_code[c];
        ev_ch_d    = 3'(c);
        ev_addr_d  = addr_i[c*ADDR_W +: ADDR_W];
        n_ev       = n_ev + 4'd1;
      end
    end

    // Every active channel except the reported one is a dropped event.
    drop_sum  = {4'b0, ev_drop_q} + (CNT_W+4)'((n_ev > 4'd1) ? (n_ev - 4'd1) : 4'd0);
    ev_drop_d = ev_drop_q;
    if (clear_i) begin
      ev_drop_d = '0;
    end else if (!freeze_i) begin
      ev_drop_d = (drop_sum[CNT_W+3:CNT_W] != 4'd0) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ev_valid_q <= 1'b0;
      ev_code_q  <= '0;
      ev_ch_q    <= '0;
      ev_addr_q  <= '0;
      ev_drop_q  <= '0;
    end else begin
      ev_valid_q <= ev_valid_d;
      ev_code_q  <= ev_code_d;
      ev_ch_q    <= ev_ch_d;
      ev_addr_q  <= ev_addr_d;
      ev_drop_q  <= ev_drop_d;
    end
  end

  assign ev_valid_o = ev_valid_q;
  assign ev_code_o  = ev_code_q;
  assign ev_ch_o    = ev_ch_q;
  assign ev_addr_o  = ev_addr_q;
  assign ev_drop_o  = ev_drop_q;
endmodule

// File: tb/tb_dcache_event_monitor.sv
// Bench for dcache_event_monitor: one single-channel 32-bit instance and one
// two-channel 4-bit-counter instance share clock and reset. Expected events
// are queued when stimulus is driven and checked when the event port fires.
module tb_dcache_event_monitor;
  import dcache_event_monitor_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  dcache_event_monitor_if #(.NUM_CH(1), .CNT_W(32), .ADDR_W(32)) if1 (.clk(clk));
  dcache_event_monitor_if #(.NUM_CH(2), .CNT_W(4),  .ADDR_W(32)) if2 (.clk(clk));

  dcache_event_monitor #(.NUM_CH(1), .CNT_W(32), .ADDR_W(32)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .stall_i(if1.stall), .idle_i(if1.idle),
    .dirty_i(if1.dirty), .rd_i(if1.rd), .wr_i(if1.wr), .addr_i(if1.addr),
    .clear_i(if1.clear), .freeze_i(if1.freeze),
    .rd_hit_o(if1.rd_hit), .wr_hit_o(if1.wr_hit), .rd_miss_o(if1.rd_miss),
    .wr_miss_o(if1.wr_miss), .wb_o(if1.wb), .ev_valid_o(if1.ev_valid),
    .ev_code_o(if1.ev_code), .ev_ch_o(if1.ev_ch), .ev_addr_o(if1.ev_addr),
    .ev_drop_o(if1.ev_drop)
  );

  dcache_event_monitor #(.NUM_CH(2), .CNT_W(4), .ADDR_W(32)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .stall_i(if2.stall), .idle_i(if2.idle),
    .dirty_i(if2.dirty), .rd_i(if2.rd), .wr_i(if2.wr), .addr_i(if2.addr),
    .clear_i(if2.clear), .freeze_i(if2.freeze),
    .rd_hit_o(if2.rd_hit), .wr_hit_o(if2.wr_hit), .rd_miss_o(if2.rd_miss),
    .wr_miss_o(if2.wr_miss), .wb_o(if2.wb), .ev_valid_o(if2.ev_valid),
    .ev_code_o(if2.ev_code), .ev_ch_o(if2.ev_ch), .ev_addr_o(if2.ev_addr),
    .ev_drop_o(if2.ev_drop)
  );

  typedef struct packed {
    logic [2:0]  code;
    logic [2:0]  ch;
    logic [31:0] addr;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  function automatic exp_t mk(input logic [2:0] code, input logic [2:0] ch,
                              input logic [31:0] addr);
    exp_t e;
    e.code = code;
    e.ch   = ch;
    e.addr = addr;
    return e;
  endfunction

  // Scoreboard consumer: every event port pulse must match the oldest entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (if1.ev_valid === 1'b1) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL ev1_unexpected got code=%0d ch=%0d addr=%h expected none",
                   if1.ev_code, if1.ev_ch, if1.ev_addr);
        end else begin
          e = q1.pop_front();
          if ({if1.ev_code, if1.ev_ch, if1.ev_addr} !== e) begin
            failures++;
            $display("FAIL ev1_match got code=%0d ch=%0d addr=%h expected code=%0d ch=%0d addr=%h",
                     if1.ev_code, if1.ev_ch, if1.ev_addr, e.code, e.ch, e.addr);
          end
        end
      end
      if (if2.ev_valid === 1'b1) begin
        checks++;
        if (q2.size() == 0) begin
          failures++;
          $display("FAIL ev2_unexpected got code=%0d ch=%0d addr=%h expected none",
                   if2.ev_code, if2.ev_ch, if2.ev_addr);
        end else begin
          e = q2.pop_front();
          if ({if2.ev_code, if2.ev_ch, if2.ev_addr} !== e) begin
            failures++;
            $display("FAIL ev2_match got code=%0d ch=%0d addr=%h expected code=%0d ch=%0d addr=%h",
                     if2.ev_code, if2.ev_ch, if2.ev_addr, e.code, e.ch, e.addr);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if1.stall = '0; if1.idle = '0; if1.dirty = '0; if1.rd = '0; if1.wr = '0;
    if1.addr = '0; if1.clear = 1'b0; if1.freeze = 1'b0;
    if2.stall = '0; if2.idle = '0; if2.dirty = '0; if2.rd = '0; if2.wr = '0;
    if2.addr = '0; if2.clear = 1'b0; if2.freeze = 1'b0;
  endtask

  task automatic do_clear();
    if1.clear = 1'b1;
    if2.clear = 1'b1;
    step();
    if1.clear = 1'b0;
    if2.clear = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    step();
    step();
    checks++;
    if ({if1.rd_hit, if1.wr_hit, if1.rd_miss, if1.wr_miss, if1.wb} !== '0) begin
      failures++;
      $display("FAIL reset_cnt1 got=%h expected=0",
               {if1.rd_hit, if1.wr_hit, if1.rd_miss, if1.wr_miss, if1.wb});
    end
    checks++;
    if ({if1.ev_valid, if1.ev_code, if1.ev_ch, if1.ev_addr, if1.ev_drop} !== '0) begin
      failures++;
      $display("FAIL reset_ev1 got valid=%b code=%0d ch=%0d addr=%h drop=%0d expected all 0",
               if1.ev_valid, if1.ev_code, if1.ev_ch, if1.ev_addr, if1.ev_drop);
    end
    checks++;
    if ({if2.rd_hit, if2.wr_hit, if2.rd_miss, if2.wr_miss, if2.wb, if2.ev_drop, if2.ev_valid} !== '0) begin
      failures++;
      $display("FAIL reset_dut2 got=%h expected=0",
               {if2.rd_hit, if2.wr_hit, if2.rd_miss, if2.wr_miss, if2.wb, if2.ev_drop, if2.ev_valid});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_read_miss_replay();
    do_clear();
    if1.addr = 32'h0000_0400; if1.rd = 1'b1; if1.dirty = 1'b0;
    if1.stall = 1'b1; if1.idle = 1'b1;
    q1.push_back(mk(EV_CODE_RD_MISS, 3'd0, 32'h0000_0400));
    step();
    if1.idle = 1'b0;
    repeat (9) step();
    if1.stall = 1'b0;
    step();
    if1.rd = 1'b0;
    step();
    checks++;
    if (if1.rd_miss !== 32'd1) begin
      failures++;
      $display("FAIL rmiss_rd_miss got=%0d expected=1", if1.rd_miss);
    end
    checks++;
    if (if1.rd_hit !== 32'd0) begin
      failures++;
      $display("FAIL rmiss_rd_hit got=%0d expected=0", if1.rd_hit);
    end
    checks++;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL rmiss_events got pending=%0d expected=0", q1.size());
    end
  endtask

  task automatic test_write_miss_wb();
    do_clear();
    if1.addr = 32'h0000_0420; if1.wr = 1'b1; if1.dirty = 1'b1;
    if1.stall = 1'b1; if1.idle = 1'b1;
    q1.push_back(mk(EV_CODE_WR_MISS_WB, 3'd0, 32'h0000_0420));
    step();
    if1.idle = 1'b0;
    step();
    if1.stall = 1'b0; if1.dirty = 1'b0;
    step();
    q1.push_back(mk(EV_CODE_WR_HIT, 3'd0, 32'h0000_0420));
    step();
    if1.wr = 1'b0;
    step();
    checks++;
    if ({if1.wr_miss, if1.wb, if1.wr_hit} !== {32'd1, 32'd1, 32'd1}) begin
      failures++;
      $display("FAIL wmiss_counts got wr_miss=%0d wb=%0d wr_hit=%0d expected 1 1 1",
               if1.wr_miss, if1.wb, if1.wr_hit);
    end
    checks++;
    if ({if1.rd_miss, if1.rd_hit} !== 64'd0) begin
      failures++;
      $display("FAIL wmiss_rd got rd_miss=%0d rd_hit=%0d expected 0 0", if1.rd_miss, if1.rd_hit);
    end
    checks++;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL wmiss_events got pending=%0d expected=0", q1.size());
    end
  endtask

  task automatic test_saturation();
    do_clear();
    if2.addr = {32'h0, 32'h0000_0800}; if2.rd = 2'b01; if2.stall = 2'b00;
    for (int i = 0; i < 17; i++) begin
      q2.push_back(mk(EV_CODE_RD_HIT, 3'd0, 32'h0000_0800));
      step();
      if (i == 13) begin
        checks++;
        if (if2.rd_hit[3:0] !== 4'hE) begin
          failures++;
          $display("FAIL sat_14 got=%h expected=e", if2.rd_hit[3:0]);
        end
      end
    end
    if2.rd = 2'b00;
    step();
    checks++;
    if (if2.rd_hit[3:0] !== 4'hF) begin
      failures++;
      $display("FAIL sat_17 got=%h expected=f", if2.rd_hit[3:0]);
    end
    checks++;
    if ({if2.rd_hit[7:4], if2.ev_drop} !== 8'h00) begin
      failures++;
      $display("FAIL sat_other got ch1=%h drop=%h expected 0 0", if2.rd_hit[7:4], if2.ev_drop);
    end
  endtask

  task automatic test_clear_freeze();
    do_clear();
    if1.addr = 32'h0000_0500; if1.rd = 1'b1;
    repeat (3) begin
      q1.push_back(mk(EV_CODE_RD_HIT, 3'd0, 32'h0000_0500));
      step();
    end
    checks++;
    if (if1.rd_hit !== 32'd3) begin
      failures++;
      $display("FAIL clr_pre got=%0d expected=3", if1.rd_hit);
    end
    if1.clear = 1'b1;
    q1.push_back(mk(EV_CODE_RD_HIT, 3'd0, 32'h0000_0500));
    step();
    if1.clear = 1'b0; if1.rd = 1'b0;
    checks++;
    if (if1.rd_hit !== 32'd0) begin
      failures++;
      $display("FAIL clr_same_edge got=%0d expected=0", if1.rd_hit);
    end
    if1.rd = 1'b1;
    q1.push_back(mk(EV_CODE_RD_HIT, 3'd0, 32'h0000_0500));
    step();
    if1.freeze = 1'b1;
    repeat (2) begin
      q1.push_back(mk(EV_CODE_RD_HIT, 3'd0, 32'h0000_0500));
      step();
    end
    if1.freeze = 1'b0; if1.rd = 1'b0;
    step();
    checks++;
    if (if1.rd_hit !== 32'd1) begin
      failures++;
      $display("FAIL freeze_hold got=%0d expected=1", if1.rd_hit);
    end
    checks++;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL clr_events got pending=%0d expected=0", q1.size());
    end
  endtask

  task automatic test_two_channel();
    do_clear();
    if2.addr = {32'h0000_0200, 32'h0000_0100};
    if2.rd = 2'b11;
    q2.push_back(mk(EV_CODE_RD_HIT, 3'd0, 32'h0000_0100));
    step();
    if2.rd = 2'b00;
    checks++;
    if ({if2.ev_drop, if2.rd_hit} !== {4'd1, 4'd1, 4'd1}) begin
      failures++;
      $display("FAIL dual_hit got drop=%0d rd_hit=%h expected drop=1 rd_hit=11",
               if2.ev_drop, if2.rd_hit);
    end
    if2.wr = 2'b10;
    q2.push_back(mk(EV_CODE_WR_HIT, 3'd1, 32'h0000_0200));
    step();
    if2.wr = 2'b00;
    step();
    checks++;
    if ({if2.wr_hit, if2.ev_drop} !== {4'd1, 4'd0, 4'd1}) begin
      failures++;
      $display("FAIL ch1_wr got wr_hit=%h drop=%0d expected wr_hit=10 drop=1",
               if2.wr_hit, if2.ev_drop);
    end
    if2.stall = 2'b11; if2.idle = 2'b11; if2.rd = 2'b01; if2.wr = 2'b10; if2.dirty = 2'b10;
    q2.push_back(mk(EV_CODE_RD_MISS, 3'd0, 32'h0000_0100));
    step();
    if2.stall = 2'b00; if2.idle = 2'b00; if2.rd = 2'b00; if2.wr = 2'b00; if2.dirty = 2'b00;
    step();
    checks++;
    if ({if2.ev_drop, if2.rd_miss, if2.wr_miss, if2.wb} !== {4'd2, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1, 4'd0}) begin
      failures++;
      $display("FAIL dual_miss got drop=%0d rd_miss=%h wr_miss=%h wb=%h expected 2 01 10 10",
               if2.ev_drop, if2.rd_miss, if2.wr_miss, if2.wb);
    end
    checks++;
    if (q2.size() != 0) begin
      failures++;
      $display("FAIL dual_events got pending=%0d expected=0", q2.size());
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    if1.addr = 32'h0000_0600; if1.rd = 1'b1; if1.stall = 1'b1; if1.idle = 1'b1;
    q1.push_back(mk(EV_CODE_RD_MISS, 3'd0, 32'h0000_0600));
    step();
    if1.idle = 1'b0;
    step();
    step();
    checks++;
    if (if1.rd_miss !== 32'd1) begin
      failures++;
      $display("FAIL arst_pre got=%0d expected=1", if1.rd_miss);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({if1.rd_hit, if1.wr_hit, if1.rd_miss, if1.wr_miss, if1.wb, if1.ev_valid,
         if1.ev_code, if1.ev_ch, if1.ev_addr, if1.ev_drop} !== '0) begin
      failures++;
      $display("FAIL arst_now got rd_miss=%0d valid=%b code=%0d expected all 0",
               if1.rd_miss, if1.ev_valid, if1.ev_code);
    end
    rst = 1'b0;
    q1.delete();
    step();
    if1.stall = 1'b0;
    q1.push_back(mk(EV_CODE_RD_HIT, 3'd0, 32'h0000_0600));
    step();
    if1.rd = 1'b0;
    step();
    checks++;
    if ({if1.rd_hit, if1.rd_miss} !== {32'd1, 32'd0}) begin
      failures++;
      $display("FAIL arst_hit got rd_hit=%0d rd_miss=%0d expected 1 0", if1.rd_hit, if1.rd_miss);
    end
    checks++;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL arst_events got pending=%0d expected=0", q1.size());
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_read_miss_replay();
    test_write_miss_wb();
    test_saturation();
    test_clear_freeze();
    test_two_channel();
    test_async_reset();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
